// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding and the
// per-stage payload widths (control/enable bits always occupy the low bits).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  typedef enum logic [1:0] {
    STG_IFID  = 2'd0,
    STG_IDEX  = 2'd1,
    STG_EXMEM = 2'd2,
    STG_MEMWB = 2'd3
  } pipe_stage_e;

  // IF/ID: pc4(32) + inst(32), no enables
  localparam int IFID_W        = 64;
  localparam int IFID_CTRL_W   = 0;
  // ID/EX: wreg, m2reg, wmem + aluc(4), aluimm, shift, jal + 4x32 operands + rn(5)
  localparam int IDEX_W        = 3 + 7 + 128 + 5;
  localparam int IDEX_CTRL_W   = 3;
  // EX/MEM: wreg, m2reg, wmem + alu(32) + b(32) + rn(5)
  localparam int EXMEM_W       = 3 + 32 + 32 + 5;
  localparam int EXMEM_CTRL_W  = 3;
  // MEM/WB: wreg, m2reg + mo(32) + alu(32) + rn(5)
  localparam int MEMWB_W       = 71;
  localparam int MEMWB_CTRL_W  = 2;

  typedef struct packed {
    logic [4:0]  rn;
    logic [31:0] alu;
    logic [31:0] mo;
    logic        m2reg;
    logic        wreg;
  } memwb_t;

  function automatic int stage_data_w(input pipe_stage_e stage);
    case (stage)
      STG_IFID:  return IFID_W;
      STG_IDEX:  return IDEX_W;
      STG_EXMEM: return EXMEM_W;
      default:   return MEMWB_W;
    endcase
  endfunction

  function automatic int stage_ctrl_w(input pipe_stage_e stage);
    case (stage)
      STG_IFID:  return IFID_CTRL_W;
      STG_IDEX:  return IDEX_CTRL_W;
      STG_EXMEM: return EXMEM_CTRL_W;
      default:   return MEMWB_CTRL_W;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/payload link between two pipeline stages. The producer side
// uses the master modport, the consumer side the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 71
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stall_counter.sv
// Saturating event counter used to measure downstream back-pressure cycles.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // Sticks at all-ones so a long stall never wraps back to a small value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble masking of
// the low enable bits and a stall counter. Define PIPE_SKID_EN for a skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = MEMWB_W,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  // Ones in the enable-bit positions; one bit wider so CTRL_W == DATA_W works
  localparam logic [DATA_W:0] CTRL_MASK_X =
    ({{DATA_W{1'b0}}, 1'b1} << CTRL_W) - {{DATA_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] CTRL_MASK = CTRL_MASK_X[DATA_W-1:0];

  pipe_state_e       r_state;
  pipe_state_e       w_nextState;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_outData;
  logic              w_inReady;
  logic              w_outValid;
  logic              w_accept;
  logic              w_emit;
  logic              w_loadMain;
  logic              w_stallInc;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] r_skidData;
  logic              w_loadSkid;
  logic              w_skidToMain;
`endif

  assign w_outValid = (r_state != ST_EMPTY);
`ifdef PIPE_SKID_EN
  assign w_inReady  = (r_state != ST_SKID);
`else
  assign w_inReady  = !w_outValid || dn.ready;
`endif
  assign w_accept   = up.valid && w_inReady;
  assign w_emit     = w_outValid && dn.ready;
  assign w_stallInc = w_outValid && !dn.ready && !flush;

  always_comb begin
    w_nextState = r_state;
    w_loadMain  = 1'b0;
`ifdef PIPE_SKID_EN
    w_loadSkid   = 1'b0;
    w_skidToMain = 1'b0;
`endif
    if (flush) begin
      w_nextState = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_nextState = ST_FULL;
            w_loadMain  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_emit && w_accept) begin
            w_loadMain = 1'b1;
          end else if (w_emit) begin
            w_nextState = ST_EMPTY;
`ifdef PIPE_SKID_EN
          end else if (w_accept) begin
            w_nextState = ST_SKID;
            w_loadSkid  = 1'b1;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        // Skid entry is always the younger beat, so it refills main in order
        ST_SKID: begin
          if (w_emit) begin
            w_nextState  = ST_FULL;
            w_skidToMain = 1'b1;
          end
        end
`endif
        default: begin
          w_nextState = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
`ifdef PIPE_SKID_EN
      r_skidData <= '0;
`endif
    end else begin
      r_state <= w_nextState;
      if (w_loadMain) begin
        r_data <= up.data;
`ifdef PIPE_SKID_EN
      end else if (w_skidToMain) begin
        r_data <= r_skidData;
`endif
      end
`ifdef PIPE_SKID_EN
      if (w_loadSkid) begin
        r_skidData <= up.data;
      end
`endif
    end
  end

  // A bubble must never present an asserted write/select enable downstream
  assign w_outData = w_outValid ? r_data : (r_data & ~CTRL_MASK);

  assign up.ready = w_inReady;
  assign dn.valid = w_outValid;
  assign dn.data  = w_outData;

  pipe_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stallCounter (
    .clock (clock),
    .reset (reset),
    .inc   (w_stallInc),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule
